// File: rtl/kbd_pkg.sv
// Shared scancodes, logical key set and frame-decoder states for the
// PS/2 cursor front end.
package kbd_pkg;

   localparam logic [7:0] SC_EXT     = 8'hE0;
   localparam logic [7:0] SC_BRK     = 8'hF0;
   localparam logic [7:0] SC_A       = 8'h1C;
   localparam logic [7:0] SC_D       = 8'h23;
   localparam logic [7:0] SC_W       = 8'h1D;
   localparam logic [7:0] SC_S       = 8'h1B;
   localparam logic [7:0] SC_L       = 8'h4B;
   localparam logic [7:0] SC_R       = 8'h2D;
   localparam logic [7:0] SC_ENTER   = 8'h5A;
   localparam logic [7:0] SC_X_LEFT  = 8'h6B;
   localparam logic [7:0] SC_X_RIGHT = 8'h74;
   localparam logic [7:0] SC_X_UP    = 8'h75;
   localparam logic [7:0] SC_X_DOWN  = 8'h72;

   typedef enum logic [2:0] {
      KEY_LEFT, KEY_RIGHT, KEY_UP, KEY_DOWN,
      KEY_LCLICK, KEY_RCLICK, KEY_RESTART, KEY_NONE
   } key_t;

   localparam int NUM_KEYS = 7;

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} dec_state_t;

   function automatic key_t map_code(input logic ext, input logic [7:0] code);
      key_t k;
      k = KEY_NONE;
      if (ext) begin
         case (code)
            SC_X_LEFT:  k = KEY_LEFT;
            SC_X_RIGHT: k = KEY_RIGHT;
            SC_X_UP:    k = KEY_UP;
            SC_X_DOWN:  k = KEY_DOWN;
            default:    k = KEY_NONE;
         endcase
      end else begin
         case (code)
            SC_A:     k = KEY_LEFT;
            SC_D:     k = KEY_RIGHT;
            SC_W:     k = KEY_UP;
            SC_S:     k = KEY_DOWN;
            SC_L:     k = KEY_LCLICK;
            SC_R:     k = KEY_RCLICK;
            SC_ENTER: k = KEY_RESTART;
            default:  k = KEY_NONE;
         endcase
      end
      return k;
   endfunction

   function automatic logic is_dir(input key_t k);
      return (k == KEY_LEFT) || (k == KEY_RIGHT) || (k == KEY_UP) || (k == KEY_DOWN);
   endfunction

endpackage

// File: rtl/ps2_frame_decoder.sv
// Turns the PS/2 byte stream into make/break events on logical keys; the
// event is combinational so the consumer acts on the edge that takes the byte.
module ps2_frame_decoder
   import kbd_pkg::*;
(
   input  logic       clk,
   input  logic       srst,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   output logic       key_evt,
   output key_t       evt_key,
   output logic       evt_make
);

   dec_state_t state_reg, state_next;
   key_t       code_key;

   always_ff @(posedge clk) begin
      if (srst) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      code_key   = KEY_NONE;
      evt_make   = 1'b0;
      key_evt    = 1'b0;
      evt_key    = KEY_NONE;
      if (rx_valid) begin
         case (state_reg)
            IDLE: begin
               if (rx_byte == SC_BRK)      state_next = BRK;
               else if (rx_byte == SC_EXT) state_next = EXT;
               else begin
                  code_key = map_code(1'b0, rx_byte);
                  evt_make = 1'b1;
               end
            end
            EXT: begin
               if (rx_byte == SC_BRK) state_next = EXT_BRK;
               else begin
                  state_next = IDLE;
                  code_key   = map_code(1'b1, rx_byte);
                  evt_make   = 1'b1;
               end
            end
            BRK: begin
               state_next = IDLE;
               code_key   = map_code(1'b0, rx_byte);
            end
            EXT_BRK: begin
               state_next = IDLE;
               code_key   = map_code(1'b1, rx_byte);
            end
            default: state_next = IDLE;
         endcase
      end
      // Unmapped codes still complete the frame but produce no event.
      if (code_key != KEY_NONE) begin
         key_evt = 1'b1;
         evt_key = code_key;
      end else begin
         evt_make = 1'b0;
      end
   end

endmodule

// File: rtl/kbd_cursor_ctrl.sv
// Keyboard cursor controller: held-key tracking, cursor stepping, click and
// restart pulses. Define KBD_AUTOREPEAT_EN to build the auto-repeat engine.
module kbd_cursor_ctrl
   import kbd_pkg::*;
#(
   parameter  int GRID_W       = 15,
   parameter  int GRID_H       = 15,
   parameter  int WRAP_EN      = 0,
   parameter  int REPEAT_DELAY = 12_500_000,
   parameter  int REPEAT_RATE  = 2_500_000,
   localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1,
   localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1
)(
   input  logic          clk_pix,
   input  logic          sim_rst,
   input  logic [7:0]    rx_byte,
   input  logic          rx_valid,
   output logic [XW-1:0] cursor_x,
   output logic [YW-1:0] cursor_y,
   output logic          cell_click,
   output logic          right_click,
   output logic [XW-1:0] clicked_cell_x,
   output logic [YW-1:0] clicked_cell_y,
   output logic          restart_game
);

   localparam int CW = ((XW > YW) ? XW : YW) + 1;
   localparam logic [CW-1:0] ONE = CW'(1);

   logic                key_evt, evt_make, fresh_make, rep_step;
   key_t                evt_key, step_key, rep_key;
   logic [NUM_KEYS-1:0] held_reg, key_sel;
   logic [XW-1:0]       cursor_x_reg, cursor_x_next, clicked_x_reg;
   logic [YW-1:0]       cursor_y_reg, cursor_y_next, clicked_y_reg;
   logic                cell_click_reg, right_click_reg, restart_reg;
   logic [CW-1:0]       x_inc, x_dec, y_inc, y_dec;

   ps2_frame_decoder u_dec (
      .clk      (clk_pix),
      .srst     (sim_rst),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid),
      .key_evt  (key_evt),
      .evt_key  (evt_key),
      .evt_make (evt_make)
   );

   // Widened so decrement from 0 and increment past the last cell stay visible.
   function automatic logic [CW-1:0] bump(input logic [CW-1:0] v, input logic up,
                                          input logic [CW-1:0] lim);
      logic [CW-1:0] r;
      if (up) begin
         r = v + ONE;
         if (r >= lim) r = (WRAP_EN != 0) ? '0 : lim - ONE;
      end else if (v == '0) begin
         r = (WRAP_EN != 0) ? lim - ONE : '0;
      end else begin
         r = v - ONE;
      end
      return r;
   endfunction

   for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_held
      assign key_sel[gi] = (evt_key == key_t'(gi));
      always_ff @(posedge clk_pix) begin
         if (sim_rst)                      held_reg[gi] <= 1'b0;
         else if (key_evt && key_sel[gi])  held_reg[gi] <= evt_make;
      end
   end

   assign fresh_make = key_evt && evt_make && ((held_reg & key_sel) == '0);

`ifdef KBD_AUTOREPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);

   logic          rep_active_reg, rep_first_reg;
   logic [RW-1:0] rep_cnt_reg, rep_target;
   key_t          rep_key_reg;

   assign rep_target = rep_first_reg ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE);
   assign rep_step   = rep_active_reg && (rep_cnt_reg + RW'(1) == rep_target);
   assign rep_key    = rep_key_reg;

   always_ff @(posedge clk_pix) begin
      if (sim_rst) begin
         rep_active_reg <= 1'b0;
         rep_first_reg  <= 1'b0;
         rep_cnt_reg    <= '0;
         rep_key_reg    <= KEY_NONE;
      end else if (fresh_make && is_dir(evt_key)) begin
         rep_active_reg <= 1'b1;
         rep_first_reg  <= 1'b1;
         rep_cnt_reg    <= '0;
         rep_key_reg    <= evt_key;
      end else if (key_evt && !evt_make && evt_key == rep_key_reg) begin
         rep_active_reg <= 1'b0;
         rep_cnt_reg    <= '0;
      end else if (rep_step) begin
         rep_first_reg  <= 1'b0;
         rep_cnt_reg    <= '0;
      end else if (rep_active_reg) begin
         rep_cnt_reg    <= rep_cnt_reg + RW'(1);
      end
   end
`else
   assign rep_step = 1'b0;
   assign rep_key  = KEY_NONE;
`endif

   assign x_inc = bump(CW'(cursor_x_reg), 1'b1, CW'(GRID_W));
   assign x_dec = bump(CW'(cursor_x_reg), 1'b0, CW'(GRID_W));
   assign y_inc = bump(CW'(cursor_y_reg), 1'b1, CW'(GRID_H));
   assign y_dec = bump(CW'(cursor_y_reg), 1'b0, CW'(GRID_H));

   // A decoded key event in the same cycle suppresses a repeat step.
   always_comb begin
      step_key      = KEY_NONE;
      cursor_x_next = cursor_x_reg;
      cursor_y_next = cursor_y_reg;
      if (fresh_make && is_dir(evt_key)) step_key = evt_key;
      else if (rep_step && !key_evt)     step_key = rep_key;
      case (step_key)
         KEY_LEFT:  cursor_x_next = x_dec[XW-1:0];
         KEY_RIGHT: cursor_x_next = x_inc[XW-1:0];
         KEY_UP:    cursor_y_next = y_dec[YW-1:0];
         KEY_DOWN:  cursor_y_next = y_inc[YW-1:0];
         default: ;
      endcase
   end

   always_ff @(posedge clk_pix) begin
      if (sim_rst) begin
         cursor_x_reg    <= '0;
         cursor_y_reg    <= '0;
         clicked_x_reg   <= '0;
         clicked_y_reg   <= '0;
         cell_click_reg  <= 1'b0;
         right_click_reg <= 1'b0;
         restart_reg     <= 1'b0;
      end else begin
         cursor_x_reg    <= cursor_x_next;
         cursor_y_reg    <= cursor_y_next;
         cell_click_reg  <= fresh_make && (evt_key == KEY_LCLICK);
         right_click_reg <= fresh_make && (evt_key == KEY_RCLICK);
         restart_reg     <= key_evt && !evt_make && (evt_key == KEY_RESTART);
         if (fresh_make && (evt_key == KEY_LCLICK || evt_key == KEY_RCLICK)) begin
            clicked_x_reg <= cursor_x_reg;
            clicked_y_reg <= cursor_y_reg;
         end
      end
   end

   assign cursor_x       = cursor_x_reg;
   assign cursor_y       = cursor_y_reg;
   assign clicked_cell_x = clicked_x_reg;
   assign clicked_cell_y = clicked_y_reg;
   assign cell_click     = cell_click_reg;
   assign right_click    = right_click_reg;
   assign restart_game   = restart_reg;

endmodule

// File: tb/tb_kbd_cursor_ctrl.sv
// Self-checking bench for kbd_cursor_ctrl: clamp, wrap and fast-repeat
// instances share one byte stream and are checked against a frame-level model.
module tb_kbd_cursor_ctrl;

   localparam int W = 15;
   localparam int H = 15;
`ifdef KBD_AUTOREPEAT_EN
   localparam int AR = 1;
`else
   localparam int AR = 0;
`endif

   logic       clk_pix = 1'b0;
   logic       sim_rst = 1'b1;
   logic [7:0] rx_byte = 8'h00;
   logic       rx_valid = 1'b0;

   logic [3:0] c_x, c_y, c_cx, c_cy, w_x, w_y, w_cx, w_cy, r_x, r_y, r_cx, r_cy;
   logic       c_click, c_rclick, c_restart, w_click, w_rclick, w_restart;
   logic       r_click, r_rclick, r_restart;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_pix = ~clk_pix;

   kbd_cursor_ctrl #(.GRID_W(W), .GRID_H(H), .WRAP_EN(0),
                     .REPEAT_DELAY(1_000_000), .REPEAT_RATE(1_000_000)) dut (
      .clk_pix(clk_pix), .sim_rst(sim_rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
      .cursor_x(c_x), .cursor_y(c_y), .cell_click(c_click), .right_click(c_rclick),
      .clicked_cell_x(c_cx), .clicked_cell_y(c_cy), .restart_game(c_restart));

   kbd_cursor_ctrl #(.GRID_W(W), .GRID_H(H), .WRAP_EN(1),
                     .REPEAT_DELAY(1_000_000), .REPEAT_RATE(1_000_000)) dut_w (
      .clk_pix(clk_pix), .sim_rst(sim_rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
      .cursor_x(w_x), .cursor_y(w_y), .cell_click(w_click), .right_click(w_rclick),
      .clicked_cell_x(w_cx), .clicked_cell_y(w_cy), .restart_game(w_restart));

   kbd_cursor_ctrl #(.GRID_W(W), .GRID_H(H), .WRAP_EN(0),
                     .REPEAT_DELAY(10), .REPEAT_RATE(4)) dut_r (
      .clk_pix(clk_pix), .sim_rst(sim_rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
      .cursor_x(r_x), .cursor_y(r_y), .cell_click(r_click), .right_click(r_rclick),
      .clicked_cell_x(r_cx), .clicked_cell_y(r_cy), .restart_game(r_restart));

   // ---------------- reference model (frame level) ----------------
   bit m_ext, m_brk;
   bit m_held[7];
   int m_x, m_y, m_wx, m_wy, m_cx, m_cy;
   bit m_click, m_rclick, m_restart;

   function automatic int lookup(input bit ext, input logic [7:0] b);
      case ({ext, b})
         9'h01C, 9'h16B: return 0;
         9'h023, 9'h174: return 1;
         9'h01D, 9'h175: return 2;
         9'h01B, 9'h172: return 3;
         9'h04B:         return 4;
         9'h02D:         return 5;
         9'h05A:         return 6;
         default:        return -1;
      endcase
   endfunction

   function automatic int clampf(input int v, input int n);
      return (v < 0) ? 0 : ((v > n - 1) ? n - 1 : v);
   endfunction

   task automatic model_byte(input logic [7:0] b);
      int k;
      bit make;
      m_click = 0; m_rclick = 0; m_restart = 0;
      if (!m_brk && b == 8'hF0) begin m_brk = 1; return; end
      if (!m_brk && !m_ext && b == 8'hE0) begin m_ext = 1; return; end
      k = lookup(m_ext, b);
      make = !m_brk;
      m_ext = 0; m_brk = 0;
      if (k < 0) return;
      if (make && !m_held[k]) begin
         case (k)
            0: begin m_x = clampf(m_x - 1, W); m_wx = (m_wx + W - 1) % W; end
            1: begin m_x = clampf(m_x + 1, W); m_wx = (m_wx + 1) % W; end
            2: begin m_y = clampf(m_y - 1, H); m_wy = (m_wy + H - 1) % H; end
            3: begin m_y = clampf(m_y + 1, H); m_wy = (m_wy + 1) % H; end
            4: begin m_click = 1; m_cx = m_x; m_cy = m_y; end
            5: begin m_rclick = 1; m_cx = m_x; m_cy = m_y; end
            default: ;
         endcase
      end
      if (k == 6 && !make) m_restart = 1;
      m_held[k] = make;
   endtask

   task automatic model_reset();
      m_ext = 0; m_brk = 0;
      foreach (m_held[i]) m_held[i] = 0;
      m_x = 0; m_y = 0; m_wx = 0; m_wy = 0; m_cx = 0; m_cy = 0;
      m_click = 0; m_rclick = 0; m_restart = 0;
   endtask

   // ---------------- stimulus helpers (entered and left at a negedge) ----------------
   task automatic send_byte(input logic [7:0] b);
      rx_byte = b;
      rx_valid = 1'b1;
      model_byte(b);
      @(negedge clk_pix);
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk_pix);
         m_click = 0; m_rclick = 0; m_restart = 0;
      end
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      sim_rst = 1'b1;
      @(negedge clk_pix);
      sim_rst = 1'b0;
      model_reset();
   endtask

   task automatic press(input logic [7:0] b, input int times);
      for (int i = 0; i < times; i++) begin
         send_byte(b); send_byte(8'hF0); send_byte(b);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      n_vec++;
      if ({c_x, c_y, c_cx, c_cy} !== 16'h0 || {c_click, c_rclick, c_restart} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_state got xy=(%0d,%0d) clk=(%0d,%0d) pulses=%b want all 0",
                  c_x, c_y, c_cx, c_cy, {c_click, c_rclick, c_restart});
      end
      $display("reset: cursor=(%0d,%0d)", c_x, c_y);
   endtask

   task automatic test_basic();
      do_reset();
      send_byte(8'h23);
      n_vec++;
      if (c_x !== 4'd1 || c_y !== 4'd0 || {c_click, c_rclick, c_restart} !== 3'b000) begin
         n_err++;
         $display("FAIL basic_make got (%0d,%0d) pulses=%b want (1,0) 000",
                  c_x, c_y, {c_click, c_rclick, c_restart});
      end
      send_byte(8'hF0); send_byte(8'h23); idle(2);
      n_vec++;
      if (c_x !== 4'd1 || c_y !== 4'd0) begin
         n_err++;
         $display("FAIL basic_break got (%0d,%0d) want (1,0)", c_x, c_y);
      end
      $display("basic: 23 F0 23 -> cursor=(%0d,%0d)", c_x, c_y);
   endtask

   task automatic test_edges();
      do_reset();
      press(8'h23, 14); press(8'h1B, 3);
      n_vec++;
      if (c_x !== 4'd14 || c_y !== 4'd3 || w_x !== 4'd14 || w_y !== 4'd3) begin
         n_err++;
         $display("FAIL edge_setup got clamp=(%0d,%0d) wrap=(%0d,%0d) want (14,3)", c_x, c_y, w_x, w_y);
      end
      send_byte(8'hE0); send_byte(8'h74);
      n_vec++;
      if (c_x !== 4'd14 || w_x !== 4'd0) begin
         n_err++;
         $display("FAIL edge_right got clamp_x=%0d wrap_x=%0d want 14 0", c_x, w_x);
      end
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
      do_reset();
      send_byte(8'h1C);
      n_vec++;
      if (c_x !== 4'd0 || w_x !== 4'd14) begin
         n_err++;
         $display("FAIL edge_left got clamp_x=%0d wrap_x=%0d want 0 14", c_x, w_x);
      end
      send_byte(8'hF0); send_byte(8'h1C);
      send_byte(8'hE0); send_byte(8'h75);
      n_vec++;
      if (c_y !== 4'd0 || w_y !== 4'd14) begin
         n_err++;
         $display("FAIL edge_up got clamp_y=%0d wrap_y=%0d want 0 14", c_y, w_y);
      end
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      $display("edges: clamp=(%0d,%0d) wrap=(%0d,%0d)", c_x, c_y, w_x, w_y);
   endtask

   task automatic test_clicks();
      logic [7:0] seq_l[5] = '{8'h4B, 8'h4B, 8'h4B, 8'hF0, 8'h4B};
      logic [7:0] seq_r[3] = '{8'h2D, 8'hF0, 8'h2D};
      int clicks = 0, rclicks = 0;
      do_reset();
      press(8'h23, 5); press(8'h1B, 7);
      foreach (seq_l[i]) begin
         send_byte(seq_l[i]);
         if (c_click === 1'b1) clicks++;
         if (i == 0) begin
            n_vec++;
            if (c_click !== 1'b1) begin
               n_err++;
               $display("FAIL click_first got %b want 1", c_click);
            end
         end
      end
      idle(1);
      if (c_click === 1'b1) clicks++;
      n_vec++;
      if (clicks != 1 || c_cx !== 4'd5 || c_cy !== 4'd7 || c_x !== 4'd5 || c_y !== 4'd7) begin
         n_err++;
         $display("FAIL left_click got pulses=%0d cell=(%0d,%0d) cur=(%0d,%0d) want 1 (5,7) (5,7)",
                  clicks, c_cx, c_cy, c_x, c_y);
      end
      foreach (seq_r[i]) begin
         send_byte(seq_r[i]);
         if (c_rclick === 1'b1) rclicks++;
      end
      idle(1);
      if (c_rclick === 1'b1) rclicks++;
      n_vec++;
      if (rclicks != 1 || c_cx !== 4'd5 || c_cy !== 4'd7 || c_click !== 1'b0) begin
         n_err++;
         $display("FAIL right_click got pulses=%0d cell=(%0d,%0d) want 1 (5,7)", rclicks, c_cx, c_cy);
      end
      $display("clicks: left=%0d right=%0d cell=(%0d,%0d)", clicks, rclicks, c_cx, c_cy);
   endtask

   task automatic test_restart();
      do_reset();
      send_byte(8'h5A);
      n_vec++;
      if (c_restart !== 1'b0) begin
         n_err++;
         $display("FAIL restart_on_make got %b want 0", c_restart);
      end
      send_byte(8'hF0);
      send_byte(8'h5A);
      n_vec++;
      if (c_restart !== 1'b1) begin
         n_err++;
         $display("FAIL restart_on_break got %b want 1", c_restart);
      end
      idle(1);
      n_vec++;
      if (c_restart !== 1'b0 || c_x !== 4'd0 || c_y !== 4'd0) begin
         n_err++;
         $display("FAIL restart_one_cycle got %b cur=(%0d,%0d) want 0 (0,0)", c_restart, c_x, c_y);
      end
      $display("restart: pulse seen and cleared");
   endtask

   task automatic test_midframe_reset();
      do_reset();
      send_byte(8'hF0);
      do_reset();
      send_byte(8'h1B);
      n_vec++;
      if (c_y !== 4'd1) begin
         n_err++;
         $display("FAIL midframe_make got y=%0d want 1", c_y);
      end
      send_byte(8'h1B);
      n_vec++;
      if (c_y !== 4'd1) begin
         n_err++;
         $display("FAIL typematic got y=%0d want 1", c_y);
      end
      send_byte(8'hF0); send_byte(8'h1B);
      send_byte(8'hE0); send_byte(8'h99);
      n_vec++;
      if (c_y !== 4'd1) begin
         n_err++;
         $display("FAIL unmapped_ext got y=%0d want 1", c_y);
      end
      send_byte(8'h1B);
      n_vec++;
      if (c_y !== 4'd2) begin
         n_err++;
         $display("FAIL after_unmapped got y=%0d want 2", c_y);
      end
      send_byte(8'hF0); send_byte(8'h1B);
      $display("midframe reset: y=%0d", c_y);
   endtask

   task automatic test_random();
      logic [7:0] base_codes[8] = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h4B, 8'h2D, 8'h5A, 8'h99};
      logic [7:0] ext_codes[6]  = '{8'h6B, 8'h74, 8'h75, 8'h72, 8'h5A, 8'h1C};
      logic [7:0] code;
      bit ext, brk;
      do_reset();
      for (int f = 0; f < 250; f++) begin
         ext = ($urandom_range(2) == 0);
         brk = ($urandom_range(1) == 0);
         code = ext ? ext_codes[$urandom_range(5)] : base_codes[$urandom_range(7)];
         if (ext) send_byte(8'hE0);
         if (brk) send_byte(8'hF0);
         send_byte(code);
         n_vec++;
         if (c_x !== 4'(m_x) || c_y !== 4'(m_y) || w_x !== 4'(m_wx) || w_y !== 4'(m_wy)) begin
            n_err++;
            $display("FAIL rand_cursor frame %0d got clamp=(%0d,%0d) wrap=(%0d,%0d) want (%0d,%0d) (%0d,%0d)",
                     f, c_x, c_y, w_x, w_y, m_x, m_y, m_wx, m_wy);
         end
         n_vec++;
         if ({c_click, c_rclick, c_restart} !== {m_click, m_rclick, m_restart} ||
             c_cx !== 4'(m_cx) || c_cy !== 4'(m_cy)) begin
            n_err++;
            $display("FAIL rand_pulse frame %0d got pulses=%b cell=(%0d,%0d) want %b (%0d,%0d)",
                     f, {c_click, c_rclick, c_restart}, c_cx, c_cy,
                     {m_click, m_rclick, m_restart}, m_cx, m_cy);
         end
         $display("frame %0d: ext=%0d brk=%0d code=%02h cursor=(%0d,%0d)", f, ext, brk, code, c_x, c_y);
         idle($urandom_range(1));
      end
   endtask

   task automatic test_autorepeat();
      int exp_y;
      do_reset();
      send_byte(8'h1B);
      n_vec++;
      if (r_y !== 4'd1) begin
         n_err++;
         $display("FAIL repeat_make got y=%0d want 1", r_y);
      end
      for (int k = 1; k <= 22; k++) begin
         idle(1);
         exp_y = 1 + ((AR != 0 && k >= 10) ? 1 + (k - 10) / 4 : 0);
         n_vec++;
         if (r_y !== 4'(exp_y)) begin
            n_err++;
            $display("FAIL repeat_hold k=%0d got y=%0d want %0d", k, r_y, exp_y);
         end
      end
      send_byte(8'hF0); send_byte(8'h1B);
      idle(12);
      exp_y = (AR != 0) ? 5 : 1;
      n_vec++;
      if (r_y !== 4'(exp_y) || c_y !== 4'd1) begin
         n_err++;
         $display("FAIL repeat_release got y=%0d main_y=%0d want %0d 1", r_y, c_y, exp_y);
      end
      $display("autorepeat (enabled=%0d): y=%0d", AR, r_y);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_edges();
      test_clicks();
      test_restart();
      test_midframe_reset();
      test_random();
      test_autorepeat();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
